// File: rtl/urv_dm_wb_bridge.sv
// urv_dm_wb_bridge: uRV data-memory port to Wishbone classic responder.
// Each load/store request pulse accepted in IDLE becomes one Wishbone
// single-beat cycle. Load data and done/error pulses go back to writeback.
// Optional build macro: URV_DM_TIMEOUT_EN adds a watchdog that aborts an
// access after TIMEOUT_CYCLES bus cycles without ack/err.
module urv_dm_wb_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_load_i,
    input  logic        dm_store_i,
    output logic        dm_ready_o,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,
    output logic        dm_bus_error_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t state, state_next;

    logic start_load;
    logic start_store;
    logic req_conflict;
    logic end_ok;
    logic end_err;
    logic timeout_hit;
    logic bus_err_q;

    // The bus is word-addressed; byte lanes are carried by wb_sel_o instead.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^dm_addr_i[1:0];

    // The watchdog is a 10-bit counter, so only 1..1023 is meaningful.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
        $error("urv_dm_wb_bridge: TIMEOUT_CYCLES must be in 1..1023");
    end

`ifdef URV_DM_TIMEOUT_EN
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 1);

    logic [9:0] to_cnt;

    // Watchdog: held at zero in IDLE, counts every bus cycle while busy.
    always_ff @(posedge clk_i) begin
        if (rst_i || state == IDLE) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 10'd1;
        end
    end

    assign timeout_hit = (to_cnt == TO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state decode: request acceptance in IDLE, termination when busy.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_next   = state;
        start_load   = 1'b0;
        start_store  = 1'b0;
        req_conflict = 1'b0;
        end_ok       = 1'b0;
        end_err      = 1'b0;
        case (state)
            IDLE: begin
                if (dm_load_i) begin
                    // Load wins a load+store collision; the store is dropped.
                    start_load   = 1'b1;
                    req_conflict = dm_store_i;
                    state_next   = READ;
                end else if (dm_store_i) begin
                    start_store = 1'b1;
                    state_next  = WRITE;
                end
            end
            READ, WRITE: begin
                // Error outranks ack; ack outranks a simultaneous timeout.
                if (wb_err_i) begin
                    end_err    = 1'b1;
                    state_next = IDLE;
                end else if (wb_ack_i) begin
                    end_ok     = 1'b1;
                    state_next = IDLE;
                end else if (timeout_hit) begin
                    end_err    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register plus registered bus controls, read data and pulses.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments keep every register here sampling
        // the pre-edge values, independent of statement order.
        if (rst_i) begin
            state           <= IDLE;
            wb_cyc_o        <= 1'b0;
            wb_stb_o        <= 1'b0;
            wb_we_o         <= 1'b0;
            wb_adr_o        <= '0;
            wb_dat_o        <= '0;
            wb_sel_o        <= '0;
            dm_data_l_o     <= '0;
            dm_load_done_o  <= 1'b0;
            dm_store_done_o <= 1'b0;
            bus_err_q       <= 1'b0;
        end else begin
            state           <= state_next;
            dm_load_done_o  <= 1'b0;
            dm_store_done_o <= 1'b0;
            bus_err_q       <= 1'b0;

            if (start_load || start_store) begin
                wb_adr_o <= {dm_addr_i[31:2], 2'b00};
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
                wb_we_o  <= start_store;
                wb_sel_o <= start_store ? dm_data_select_i : 4'b1111;
            end
            if (start_store) begin
                wb_dat_o <= dm_data_s_i;
            end

            if (end_ok || end_err) begin
                wb_cyc_o <= 1'b0;
                wb_stb_o <= 1'b0;
            end
            if (end_ok && state == READ) begin
                dm_data_l_o    <= wb_dat_i;
                dm_load_done_o <= 1'b1;
            end
            if (end_ok && state == WRITE) begin
                dm_store_done_o <= 1'b1;
            end
            if (end_err) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    // Ready is a pure state decode so the core's stall loop stays registered.
    assign dm_ready_o = (state == IDLE);

    // A dropped store from a collision is reported in its request cycle.
    assign dm_bus_error_o = bus_err_q | req_conflict;

endmodule

// File: tb/tb_urv_dm_wb_bridge.sv
// tb_urv_dm_wb_bridge: directed scoreboard bench for urv_dm_wb_bridge.
// Stimulus pushes expected writeback events; a negedge monitor pops and
// compares them whenever a done/error pulse appears.
// Timeout scenarios are compiled only when URV_DM_TIMEOUT_EN is defined.
module tb_urv_dm_wb_bridge;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] dm_addr_i = '0;
    logic [31:0] dm_data_s_i = '0;
    logic [3:0]  dm_data_select_i = '0;
    logic        dm_load_i = 1'b0;
    logic        dm_store_i = 1'b0;
    logic        dm_ready_o;
    logic [31:0] dm_data_l_o;
    logic        dm_load_done_o;
    logic        dm_store_done_o;
    logic        dm_bus_error_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;

    urv_dm_wb_bridge #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .dm_addr_i        (dm_addr_i),
        .dm_data_s_i      (dm_data_s_i),
        .dm_data_select_i (dm_data_select_i),
        .dm_load_i        (dm_load_i),
        .dm_store_i       (dm_store_i),
        .dm_ready_o       (dm_ready_o),
        .dm_data_l_o      (dm_data_l_o),
        .dm_load_done_o   (dm_load_done_o),
        .dm_store_done_o  (dm_store_done_o),
        .dm_bus_error_o   (dm_bus_error_o),
        .wb_cyc_o         (wb_cyc_o),
        .wb_stb_o         (wb_stb_o),
        .wb_we_o          (wb_we_o),
        .wb_adr_o         (wb_adr_o),
        .wb_dat_o         (wb_dat_o),
        .wb_sel_o         (wb_sel_o),
        .wb_dat_i         (wb_dat_i),
        .wb_ack_i         (wb_ack_i),
        .wb_err_i         (wb_err_i)
    );

    always #5 clk_i = ~clk_i;

    // Pulse pattern {load_done, store_done, bus_error} expected per event.
    typedef enum logic [2:0] {
        EV_LOAD  = 3'b100,
        EV_STORE = 3'b010,
        EV_ERR   = 3'b001
    } ev_t;

    typedef struct {
        ev_t         kind;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_rdata = '0;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input ev_t kind, input logic [31:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every pulse must match the oldest expected event.
    always @(negedge clk_i) begin
        logic [2:0] pulses;
        exp_t       e;
        pulses = {dm_load_done_o, dm_store_done_o, dm_bus_error_o};
        if (pulses == 3'b100 || pulses == 3'b010 || pulses == 3'b001 ||
            pulses == 3'b110 || pulses == 3'b101 || pulses == 3'b011 ||
            pulses == 3'b111) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {29'd0, pulses}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", {29'd0, pulses}, {29'd0, e.kind});
                check("dm_data_l", dm_data_l_o, e.data);
            end
        end
    end

    // Protocol monitor: the core must never request while the bridge is busy.
    always @(negedge clk_i) begin
        if (dm_load_i || dm_store_i) begin
            check("req_while_busy", {31'd0, dm_ready_o}, 32'd1);
        end
    end

    // One request, `waits` idle bus cycles, then terminate with ack and/or err.
    task automatic run_access(input string tag, input logic ld, input logic st,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] sel, input logic [31:0] rdata,
                              input int waits, input logic t_ack, input logic t_err);
        int          cyc_cnt;
        int          busy_cnt;
        logic        exp_we;
        logic [3:0]  exp_sel;
        logic [31:0] exp_adr;
        exp_we  = !ld && st;
        exp_sel = ld ? 4'hF : sel;
        exp_adr = {addr[31:2], 2'b00};
        if (ld && st) push(EV_ERR, exp_rdata);
        if (t_err) begin
            push(EV_ERR, exp_rdata);
        end else if (ld) begin
            exp_rdata = rdata;
            push(EV_LOAD, rdata);
        end else begin
            push(EV_STORE, exp_rdata);
        end

        @(posedge clk_i); #1;
        dm_load_i        = ld;
        dm_store_i       = st;
        dm_addr_i        = addr;
        dm_data_s_i      = wdata;
        dm_data_select_i = sel;
        @(negedge clk_i);
        check({tag, "_ready_at_req"}, {31'd0, dm_ready_o}, 32'd1);
        @(posedge clk_i); #1;
        // Scramble request inputs to prove the bus side was latched.
        dm_load_i        = 1'b0;
        dm_store_i       = 1'b0;
        dm_addr_i        = ~addr;
        dm_data_s_i      = ~wdata;
        dm_data_select_i = ~sel;
        cyc_cnt  = 0;
        busy_cnt = 0;
        for (int k = 0; k <= waits; k++) begin
            wb_ack_i = (k == waits) && t_ack;
            wb_err_i = (k == waits) && t_err;
            wb_dat_i = (k == waits) ? rdata : (32'hBAD0_0000 | k);
            @(negedge clk_i);
            if (wb_cyc_o && wb_stb_o) cyc_cnt++;
            if (!dm_ready_o) busy_cnt++;
            check({tag, "_wb_adr"}, wb_adr_o, exp_adr);
            check({tag, "_wb_sel"}, {28'd0, wb_sel_o}, {28'd0, exp_sel});
            check({tag, "_wb_we"}, {31'd0, wb_we_o}, {31'd0, exp_we});
            if (exp_we) check({tag, "_wb_dat"}, wb_dat_o, wdata);
            @(posedge clk_i); #1;
        end
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = '0;
        @(negedge clk_i);
        check({tag, "_cyc_cycles"}, cyc_cnt, waits + 1);
        check({tag, "_busy_cycles"}, busy_cnt, waits + 1);
        check({tag, "_cyc_after"}, {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
        check({tag, "_ready_after"}, {31'd0, dm_ready_o}, 32'd1);
    endtask

    // Hard bound on the whole run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Reset state.
        @(negedge clk_i);
        check("rst_ready", {31'd0, dm_ready_o}, 32'd1);
        check("rst_cyc_stb_we", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
        check("rst_wb_adr", wb_adr_o, 32'd0);
        check("rst_wb_dat", wb_dat_o, 32'd0);
        check("rst_wb_sel", {28'd0, wb_sel_o}, 32'd0);
        check("rst_data_l", dm_data_l_o, 32'd0);
        check("rst_pulses", {29'd0, dm_load_done_o, dm_store_done_o, dm_bus_error_o}, 32'd0);

        // Zero-wait load: busy for one cycle, ready again two cycles after request.
        run_access("zw_load", 1'b1, 1'b0, 32'h0000_1006, 32'h0, 4'h0,
                   32'hDEAD_BEEF, 0, 1'b1, 1'b0);
        // Byte store with three wait cycles.
        run_access("byte_store", 1'b0, 1'b1, 32'h0000_0020, 32'h5A5A_5A5A, 4'b0001,
                   32'h0, 3, 1'b1, 1'b0);
        // Load terminated by error: read data must stay 0xDEADBEEF.
        run_access("err_load", 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0,
                   32'h1234_5678, 1, 1'b0, 1'b1);
        // Collision: read cycle only, error pulse in the request cycle.
        run_access("collide", 1'b1, 1'b1, 32'h0000_0200, 32'h1111_2222, 4'b1100,
                   32'hCAFE_F00D, 0, 1'b1, 1'b0);
        // Word store at a misaligned address.
        run_access("word_store", 1'b0, 1'b1, 32'h0000_0ABF, 32'hA5A5_0F0F, 4'hF,
                   32'h0, 1, 1'b1, 1'b0);
        // Store terminated by err and ack together: error wins.
        run_access("err_ack_store", 1'b0, 1'b1, 32'h0000_0044, 32'h0000_00FF, 4'b0011,
                   32'h0, 2, 1'b1, 1'b1);

        // Reset after two wait cycles of a load, then a late ack.
        @(posedge clk_i); #1;
        dm_load_i = 1'b1;
        dm_addr_i = 32'h0000_0040;
        @(posedge clk_i); #1;
        dm_load_i = 1'b0;
        @(negedge clk_i);
        check("rst_mid_cyc_up", {30'd0, wb_cyc_o, wb_stb_o}, 32'd3);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i     = 1'b0;
        exp_rdata = '0;
        wb_ack_i  = 1'b1;
        wb_dat_i  = 32'h7777_7777;
        @(negedge clk_i);
        check("rst_mid_cyc_down", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
        check("rst_mid_ready", {31'd0, dm_ready_o}, 32'd1);
        check("rst_mid_data_l", dm_data_l_o, 32'd0);
        @(posedge clk_i); #1;
        wb_ack_i = 1'b0;
        wb_dat_i = '0;
        @(negedge clk_i);
        check("late_ack_ignored", {30'd0, wb_cyc_o, dm_ready_o}, 32'd1);

        // Bridge fully operational after reset.
        run_access("post_rst_load", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 4'h0,
                   32'h0BAD_C0DE, 2, 1'b1, 1'b0);

`ifdef URV_DM_TIMEOUT_EN
        begin
            int cyc_cnt;
            push(EV_ERR, exp_rdata);
            @(posedge clk_i); #1;
            dm_load_i = 1'b1;
            dm_addr_i = 32'h0000_0300;
            @(posedge clk_i); #1;
            dm_load_i = 1'b0;
            cyc_cnt   = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk_i);
                if (!wb_cyc_o) break;
                cyc_cnt++;
            end
            check("timeout_cyc_cycles", cyc_cnt, 8);
            check("timeout_ready", {31'd0, dm_ready_o}, 32'd1);
        end
        // Ack on the eighth cycle resolves as a normal completion.
        run_access("ack_at_timeout", 1'b1, 1'b0, 32'h0000_0304, 32'h0, 4'h0,
                   32'h8888_0008, 7, 1'b1, 1'b0);
`endif

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
